// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encoding, the flush counter width and the bundle of
// per-cycle control outputs, so the top-level decision logic can select
// whole control patterns instead of assigning six bits one at a time.
package pipe_ctrl_pkg;

   localparam int FLUSH_CNT_W = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } pipe_state_e;

   // One cycle's worth of stage-register enables and NOP-mux selects.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic kill_if;
      logic kill_dec;
   } pipe_ctrl_t;

   // Free-running pipeline: every register latches, nothing is killed.
   localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   // Data-memory wait: every register holds, no bubbles are inserted.
   localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   // Wrong-path squash: keep moving but replace IF and DEC with NOPs.
   localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   // Load-use bubble: hold PC and IF/ID, push a NOP into ID/EX.
   localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   // Under reset: nothing latches and both decode muxes select NOP.
   localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the load sitting in ID/EX writes a
// register that the instruction in IF/ID reads. x0 never creates a hazard
// because writes to it are discarded.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       idex_mem_read_i,
   input  logic [4:0] idex_rd_i,
   input  logic [4:0] ifid_rs1_i,
   input  logic [4:0] ifid_rs2_i,
   output logic       hazard_o
);

   logic rd_nonzero;
   logic rs_match;

   assign rd_nonzero = (idex_rd_i != 5'd0);
   assign rs_match   = (idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i);
   assign hazard_o   = idex_mem_read_i & rd_nonzero & rs_match;

endmodule : load_use_detect

// File: rtl/pipeline_control.sv
// Central stall/flush sequencer for the five-stage RV32I pipeline.
// Every cycle it picks the enables of the PC, IF/ID, ID/EX and EX/MEM
// registers and the kill selects of the decode NOP muxes. Priority, highest
// first: data-memory wait (freeze), branch mispredict (flush), load-use
// (single bubble). Outputs are Mealy: they follow the current inputs in the
// same cycle.
//
// Build option: define PIPE_PERF_EN to get the stall_cycles / flush_events
// performance counters; otherwise both outputs are tied to zero and the
// counter flops are not built. Control behaviour is identical either way.
module pipeline_control
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_DEPTH = 1   // killed cycles per mispredict, 1..15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic [4:0]  idex_rd,
   input  logic        idex_mem_read,
   input  logic        ex_mispredict,
   input  logic        mem_req_valid,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        kill_IF,
   output logic        kill_DEC,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   // Cycles still to be killed after the mispredict cycle itself.
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
   localparam bit MULTI_CYCLE_FLUSH = (FLUSH_DEPTH > 1);

   pipe_state_e             state_q, state_d;
   pipe_state_e             eff_state;
   logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic                    resume_flush_q, resume_flush_d;
   pipe_ctrl_t              ctrl;
   logic                    load_use;
   logic                    freeze;
`ifdef PIPE_PERF_EN
   logic                    stall_evt;
   logic                    flush_evt;
`endif

   load_use_detect u_load_use_detect (
      .idex_mem_read_i (idex_mem_read),
      .idex_rd_i       (idex_rd),
      .ifid_rs1_i      (ifid_rs1),
      .ifid_rs2_i      (ifid_rs2),
      .hazard_o        (load_use)
   );

   // A request that memory does not complete this cycle freezes everything.
   assign freeze = mem_req_valid & ~mem_ready;

   // Next-state and Mealy output decision, strongest trigger first.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can
      // leave one unassigned, which would infer a latch.
      state_d        = state_q;
      flush_cnt_d    = flush_cnt_q;
      resume_flush_d = resume_flush_q;
      ctrl           = CTRL_RUN;
`ifdef PIPE_PERF_EN
      stall_evt      = 1'b0;
      flush_evt      = 1'b0;
`endif

      // MEM_WAIT behaves as the state it interrupted once the freeze lifts.
      eff_state = state_q;
      if (state_q == MEM_WAIT) begin
         eff_state = resume_flush_q ? FLUSH : RUN;
      end
      state_d = eff_state;

      if (freeze) begin
         // EX is held, so a pending mispredict stays asserted and is taken on exit.
         ctrl           = CTRL_FREEZE;
         state_d        = MEM_WAIT;
         resume_flush_d = (eff_state == FLUSH);
`ifdef PIPE_PERF_EN
         stall_evt      = 1'b1;
`endif
      end else if (ex_mispredict) begin
         ctrl = CTRL_FLUSH;
`ifdef PIPE_PERF_EN
         flush_evt = 1'b1;
`endif
         if (MULTI_CYCLE_FLUSH) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
         end else begin
            state_d     = RUN;
            flush_cnt_d = '0;
         end
      end else if (eff_state == FLUSH) begin
         ctrl        = CTRL_FLUSH;
         flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
         if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
            state_d = RUN;
         end
      end else if (load_use) begin
         // The load advances into EX, so the hazard clears next cycle.
         ctrl = CTRL_BUBBLE;
`ifdef PIPE_PERF_EN
         stall_evt = 1'b1;
`endif
      end

      if (!rst) begin
         ctrl = CTRL_RESET;
      end
   end

   assign pc_en    = ctrl.pc_en;
   assign ifid_en  = ctrl.ifid_en;
   assign idex_en  = ctrl.idex_en;
   assign exmem_en = ctrl.exmem_en;
   assign kill_IF  = ctrl.kill_if;
   assign kill_DEC = ctrl.kill_dec;

   // FSM state, flush countdown and the saved pre-wait state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= RUN;
         flush_cnt_q    <= '0;
         resume_flush_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the values of
         // the same clock edge regardless of statement order.
         state_q        <= state_d;
         flush_cnt_q    <= flush_cnt_d;
         resume_flush_q <= resume_flush_d;
      end
   end

`ifdef PIPE_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_events_q;

   // Performance counters; both wrap naturally modulo 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         if (stall_evt) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (flush_evt) flush_events_q <= flush_events_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule : pipeline_control

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control with FLUSH_DEPTH=2. Each driven cycle
// pushes the expected controls and counters; a negedge monitor pops and
// compares them against the DUT outputs.
module tb_pipeline_control;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
   logic        idex_mem_read, ex_mispredict, mem_req_valid, mem_ready;
   logic        pc_en, ifid_en, idex_en, exmem_en, kill_IF, kill_DEC;
   logic [31:0] stall_cycles, flush_events;

   pipeline_control #(.FLUSH_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .ifid_rs1      (ifid_rs1),
      .ifid_rs2      (ifid_rs2),
      .idex_rd       (idex_rd),
      .idex_mem_read (idex_mem_read),
      .ex_mispredict (ex_mispredict),
      .mem_req_valid (mem_req_valid),
      .mem_ready     (mem_ready),
      .pc_en         (pc_en),
      .ifid_en       (ifid_en),
      .idex_en       (idex_en),
      .exmem_en      (exmem_en),
      .kill_IF       (kill_IF),
      .kill_DEC      (kill_DEC),
      .stall_cycles  (stall_cycles),
      .flush_events  (flush_events)
   );

   always #5 clk = ~clk;

   // ctrl bit order: {pc_en, ifid_en, idex_en, exmem_en, kill_IF, kill_DEC}
   typedef struct {
      string       tag;
      logic [5:0]  ctrl;
      logic [31:0] stalls;
      logic [31:0] flushes;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;

   // Reference model state
   int          m_left;      // killed cycles still owed by the last mispredict
   logic [31:0] m_stalls;
   logic [31:0] m_flushes;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_PERF_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic drive(input string tag, input logic r, input logic misp,
                        input logic req, input logic rdy, input logic mrd,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      exp_t e;
      logic hz;
      @(posedge clk);
      #1;
      rst = r; ex_mispredict = misp; mem_req_valid = req; mem_ready = rdy;
      idex_mem_read = mrd; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
      e.tag = tag;
      hz = mrd && (rd != 5'd0) && (rd == rs1 || rd == rs2);
      if (!r) begin
         m_left = 0; m_stalls = 0; m_flushes = 0;
         e.ctrl = 6'b000011;
      end else if (req && !rdy) begin
         e.ctrl = 6'b000000;
      end else if (misp) begin
         e.ctrl = 6'b111111;
      end else if (m_left > 0) begin
         e.ctrl = 6'b111111;
      end else if (hz) begin
         e.ctrl = 6'b001101;
      end else begin
         e.ctrl = 6'b111100;
      end
      e.stalls  = perf(m_stalls);
      e.flushes = perf(m_flushes);
      if (r) begin
         if (req && !rdy) m_stalls++;
         else if (misp) begin m_flushes++; m_left = DEPTH - 1; end
         else if (m_left > 0) m_left--;
         else if (hz) m_stalls++;
      end
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: compare mid-cycle, away from the rising edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({e.tag, ".ctrl"},
               {26'd0, pc_en, ifid_en, idex_en, exmem_en, kill_IF, kill_DEC},
               {26'd0, e.ctrl});
         check({e.tag, ".stall_cycles"}, stall_cycles, e.stalls);
         check({e.tag, ".flush_events"}, flush_events, e.flushes);
      end
   end

   initial begin
      rst = 1'b0; ex_mispredict = 1'b0; mem_req_valid = 1'b0; mem_ready = 1'b0;
      idex_mem_read = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
      m_left = 0; m_stalls = 0; m_flushes = 0;

      // Reset and first idle cycle
      drive("reset",      0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("reset2",     0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("idle",       1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Load-use variants
      drive("lu_rs1",     1, 0, 0, 0, 1, 5'd10, 5'd10, 5'd3);
      drive("lu_after",   1, 0, 0, 0, 0, 5'd10, 5'd10, 5'd3);
      drive("lu_rs2",     1, 0, 0, 0, 1, 5'd7,  5'd1,  5'd7);
      drive("lu_rd0",     1, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0);
      drive("lu_noload",  1, 0, 0, 0, 0, 5'd10, 5'd10, 5'd10);
      drive("lu_nomatch", 1, 0, 0, 0, 1, 5'd9,  5'd8,  5'd6);

      // Memory wait: three frozen cycles, then release
      repeat (3) drive("mw_freeze", 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      drive("mw_exit",    1, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0);
      drive("mw_sameclk", 1, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0);
      drive("mw_idle",    1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Mispredict, two killed cycles
      drive("mp",         1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("mp_flush",   1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("mp_done",    1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Mispredict beats load-use, and flush cycle beats load-use
      drive("mp_lu",      1, 1, 0, 0, 1, 5'd10, 5'd10, 5'd0);
      drive("mp_lu_fl",   1, 0, 0, 0, 1, 5'd10, 5'd10, 5'd0);
      drive("mp_lu_done", 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Mispredict held through a 2-cycle freeze
      repeat (2) drive("fz_mp", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      drive("fz_mp_exit", 1, 1, 1, 1, 0, 5'd0,  5'd0,  5'd0);
      drive("fz_mp_fl",   1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("fz_mp_done", 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Freeze in the middle of a flush resumes the flush
      drive("fl_mp",      1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("fl_fz",      1, 0, 1, 0, 1, 5'd4,  5'd4,  5'd0);
      drive("fl_fz_exit", 1, 0, 1, 1, 1, 5'd4,  5'd4,  5'd0);
      drive("fl_fz_done", 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Back-to-back mispredicts reload the count
      drive("mp2_a",      1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("mp2_b",      1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("mp2_fl",     1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("mp2_done",   1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Asynchronous reset mid-flush
      drive("rst_mp",     1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("rst_fl",     0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("rst_hold",   0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);
      drive("rst_rel",    1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0);

      // Random mix
      for (int i = 0; i < 300; i++) begin
         logic r, mp, rq, rdy, mrd;
         r   = ($urandom_range(0, 63) != 0);
         mp  = ($urandom_range(0, 7) == 0);
         rq  = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 1) == 0);
         mrd = ($urandom_range(0, 1) == 0);
         drive("rand", r, mp, rq, rdy, mrd, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      repeat (2) @(posedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pipeline_control

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the five-stage RV32I pipeline. It decides, every cycle, which pipeline registers (PC, IF/ID, ID/EX, EX/MEM) latch and which stages are replaced by `INST_NOP` bubbles. The three triggers are:
- data-memory wait,
- branch mispredict resolved in EX,
- load-use hazards between IF/ID and ID/EX.

It drives the `en` inputs of the stage registers and the `kill_IF`/`kill_DEC` selects of the decode NOP muxes.

## Interface
- `FLUSH_DEPTH`, default 1: cycles `kill_IF`/`kill_DEC` stay asserted per mispredict (1..15).
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ifid_rs1` in 5: rs1 field of instruction in IF/ID.
- `ifid_rs2` in 5: rs2 field of instruction in IF/ID.
- `idex_rd` in 5: rd of instruction in ID/EX.
- `idex_mem_read` in 1: instruction in ID/EX is a load.
- `ex_mispredict` in 1: EX resolved a control transfer against the prediction.
- `mem_req_valid` in 1: MEM stage holds an active data-memory request.
- `mem_ready` in 1: data memory completes the request this cycle.
- `pc_en` out 1: PC register enable.
- `ifid_en` out 1: IF/ID register enable.
- `idex_en` out 1: ID/EX register enable.
- `exmem_en` out 1: EX/MEM register enable.
- `kill_IF` out 1: replace the fetched instruction with NOP.
- `kill_DEC` out 1: select NOP controls into ID/EX.
- `stall_cycles` out 32: count of freeze or load-use cycles. Tied to 0 unless `PIPE_PERF_EN` is defined.
- `flush_events` out 32: count of accepted mispredicts. Tied to 0 unless `PIPE_PERF_EN` is defined.

## Operation
- States: RUN, FLUSH, MEM_WAIT, held in a 2-bit register.
- Outputs are Mealy: combinational from state and current inputs.
- Priority, highest first: memory wait, mispredict/flush, load-use.

**Memory wait**
- Condition: `mem_req_valid & ~mem_ready`, evaluated in any state.
- Freeze: all four enables 0, kills 0, next state MEM_WAIT.
- The FLUSH counter holds during a freeze.
- Exit: `mem_ready`=1 in MEM_WAIT. That cycle, enables return per the lower-priority rules and the state returns to the pre-wait state (RUN or FLUSH, saved in a 1-bit `resume_flush`).
- `ex_mispredict` during a freeze is not acted on. EX is held, so the signal persists and is taken on exit.

**Mispredict**
- Trigger: `ex_mispredict`=1 with no freeze.
- That cycle: `kill_IF`=`kill_DEC`=1, all enables 1, `flush_events`+1.
- If `FLUSH_DEPTH`>1: enter FLUSH with `flush_cnt`=`FLUSH_DEPTH`-1. Otherwise stay in RUN.
- In FLUSH: kills remain 1, enables 1, `flush_cnt` decrements each unfrozen cycle, and the state returns to RUN on the cycle `flush_cnt`==1 is consumed.
- A new `ex_mispredict` in FLUSH reloads `flush_cnt` and counts a new event.

**Load-use**
- Condition: `idex_mem_read` & `idex_rd`!=0 & (`idex_rd`==`ifid_rs1` | `idex_rd`==`ifid_rs2`), in RUN only, with no freeze and no mispredict.
- Response: `pc_en`=`ifid_en`=0, `idex_en`=`exmem_en`=1, `kill_DEC`=1, `kill_IF`=0.
- This is exactly one bubble. The load advances, so the condition clears next cycle. No state change.

**Idle RUN**
- All enables 1, kills 0.

**Reset**
- While `rst`=0: state RUN, `flush_cnt`=0, `resume_flush`=0, counters 0.
- Outputs during reset: all enables 0, `kill_IF`=`kill_DEC`=1.

## Timing
- Zero-cycle decision latency: outputs respond to inputs in the same cycle. State and counters update on the `clk` rising edge.
- Freeze lasts exactly the number of cycles with `mem_ready`=0 while `mem_req_valid`=1.
- Load-use costs 1 cycle. A mispredict costs `FLUSH_DEPTH` killed cycles.
- Simultaneous events:
  - Mispredict + load-use: mispredict wins; the hazard instruction is killed.
  - Freeze + mispredict: freeze wins.
  - `mem_ready` on the same cycle `mem_req_valid` rises: no freeze.
- Asynchronous reset mid-FLUSH or mid-MEM_WAIT returns to RUN immediately. Pending flush is discarded.
- Counters wrap modulo 2^32.

## Configuration
- `PIPE_PERF_EN` defined: `stall_cycles` increments on every freeze cycle and every load-use bubble cycle. `flush_events` increments on every accepted mispredict.
- Not defined: both outputs are constant 0 and no counter flops exist. Control behaviour is identical either way.

## Structure
- Shared package `pipe_ctrl_pkg`: state encodings RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2; `FLUSH_CNT_W`=4. NOP encoding stays `INST_NOP` in `defines.vh`.
- One sub-module, `load_use_detect`: combinational compare of `idex_rd` against rs1/rs2, producing a hazard flag. The state machine and counters live in `pipeline_control`.

## Test plan
- **Load-use:** `idex_mem_read`=1, `idex_rd`=5'd10, `ifid_rs1`=5'd10 for 1 cycle → `pc_en`=`ifid_en`=0, `kill_DEC`=1 for exactly 1 cycle; with `idex_rd`=0, no stall.
- **Memory wait:** `mem_req_valid`=1, `mem_ready`=0 for 3 cycles, then 1 → all enables 0 for 3 cycles, state MEM_WAIT, `stall_cycles`=3; enables 1 on the 4th cycle.
- **Mispredict depth 2:** `FLUSH_DEPTH`=2, `ex_mispredict` pulse → `kill_IF`/`kill_DEC`=1 for 2 cycles, `flush_events`=1, state back to RUN.
- **Simultaneous events:** mispredict + load-use in the same cycle → kills 1, `pc_en`=1 (no load-use stall). Mispredict held during a 2-cycle freeze → flush starts on the `mem_ready` cycle.
- **Reset:** `rst` low in FLUSH mid-count → outputs go to enables 0 and kills 1 at once. After release: RUN with all enables 1, counters 0.
- **Build without `PIPE_PERF_EN`:** rerun the memory-wait scenario → `stall_cycles`=0 and identical enable waveform.
